// File: rtl/pulse_arb_pkg.sv
// Shared types and default parameter values for the pulse-driven round-robin arbiter.
package pulse_arb_pkg;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_HOLD    = 3;
   localparam int DEF_GAP     = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;
endpackage

// File: rtl/pulse_arb_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface pulse_arb_if
   import pulse_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) ();
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic               en;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_id;
   logic               pulse;
   logic               busy;

   modport master (output en, req, input gnt, gnt_id, pulse, busy);
   modport slave  (input en, req, output gnt, gnt_id, pulse, busy);
endinterface

// File: rtl/pulse_arb_rr_pick.sv
// Combinational round-robin search: first set request at or above the pointer, wrapping.
module pulse_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic               o_vld,
   output logic [IW-1:0]      o_idx
);
   logic [IW:0] w_pos;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      o_vld = 1'b0;
      o_idx = '0;
      w_pos = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_pos = {1'b0, i_ptr} + (IW+1)'(i);
         if (w_pos >= (IW+1)'(NUM_REQ))
            w_pos = w_pos - (IW+1)'(NUM_REQ);
         if (i_req[w_pos[IW-1:0]]) begin
            o_vld = 1'b1;
            o_idx = w_pos[IW-1:0];
         end
      end
   end
endmodule

// File: rtl/pulse_arb.sv
// Non-preemptive round-robin arbiter: HOLD-cycle grants with a start pulse, then GAP idle cycles.
module pulse_arb
   import pulse_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int HOLD    = DEF_HOLD,
   parameter int GAP     = DEF_GAP
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   pulse_arb_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HW = $clog2(HOLD + 1);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $fatal(1, "pulse_arb: NUM_REQ=%0d outside 2..16", NUM_REQ);
   end
   if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
      $fatal(1, "pulse_arb: HOLD=%0d outside 1..255", HOLD);
   end
   if (GAP < 0 || GAP > 15) begin : g_bad_gap
      $fatal(1, "pulse_arb: GAP=%0d outside 0..15", GAP);
   end

   state_t             r_state;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_gnt_id;
   logic [NUM_REQ-1:0] r_gnt;
   logic [HW-1:0]      r_hold;
   logic [3:0]         r_gap;
   logic               r_pulse;
   logic               r_busy;

   logic               w_vld;
   logic [IW-1:0]      w_idx;
   logic [IW-1:0]      w_nxt_ptr;

   pulse_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_vld (w_vld),
      .o_idx (w_idx)
   );

   assign w_nxt_ptr = (r_gnt_id == IW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_gnt_id <= '0;
         r_gnt    <= '0;
         r_hold   <= '0;
         r_gap    <= '0;
         r_pulse  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.en && w_vld) begin
                  r_state  <= ST_GRANT;
                  r_gnt    <= NUM_REQ'(1) << w_idx;
                  r_gnt_id <= w_idx;
                  r_pulse  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_hold   <= HW'(1);
               end
            end
            ST_GRANT: begin
               r_pulse <= 1'b0;
               // en and req are ignored here: a grant always runs its full length.
               if (r_hold == HW'(HOLD)) begin
                  r_ptr    <= w_nxt_ptr;
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_hold   <= '0;
                  if (GAP == 0) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_GAP;
                     r_gap   <= 4'd1;
                  end
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_gap == 4'(GAP)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_gap   <= '0;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt    = r_gnt;
   assign bus.gnt_id = r_gnt_id;
   assign bus.pulse  = r_pulse;
   assign bus.busy   = r_busy;
endmodule

// File: doc/pulse_arb.md
PULSE_ARB -- requirements
Module: pulse_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the pulse-driven resource; legal range 2..16.
REQ-002 Parameter HOLD, default 3: cycles a grant is held per award; legal range 1..255.
REQ-003 Parameter GAP, default 1: idle cycles inserted after each grant before the next award; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  arbitration enable; sampled every cycle.
REQ-007 req  input  NUM_REQ  per-requester request level, bit i = requester i.
REQ-008 gnt  output  NUM_REQ  one-hot grant to the current owner; all-zero when no owner.
REQ-009 gnt_id  output  $clog2(NUM_REQ)  index of current owner; 0 when no owner.
REQ-010 pulse  output  1  single-cycle start pulse to the shared resource, asserted in the first grant cycle only.
REQ-011 busy  output  1  high in GRANT and GAP states.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, GRANT and GAP.
REQ-013 In IDLE, with en=1 and any req bit set in cycle t, the block SHALL enter GRANT and assert gnt, gnt_id, pulse and busy in cycle t+1.
REQ-014 The winner SHALL be the first set req bit at or after the round-robin pointer, searching upward and wrapping from NUM_REQ-1 to 0.
REQ-015 GRANT SHALL last exactly HOLD cycles; gnt and gnt_id SHALL stay constant throughout.
REQ-016 pulse SHALL be high only in the first GRANT cycle, including when HOLD=1.
REQ-017 On leaving GRANT, the pointer SHALL become (winner+1) mod NUM_REQ.
REQ-018 After GRANT the block SHALL spend exactly GAP cycles in GAP with gnt all-zero, then enter IDLE; with GAP=0 it SHALL go directly to IDLE.
REQ-019 A grant is non-preemptive: deasserting req, or deasserting en, during GRANT SHALL NOT shorten it.
REQ-020 With en=0 in IDLE, no grant SHALL start, even if req bits are set.
REQ-021 A hold counter of width $clog2(HOLD+1) SHALL count grant cycles; it SHALL NOT wrap within a grant.
REQ-022 Requests arriving during GRANT or GAP SHALL be arbitrated only from IDLE; no request storage beyond the live req level SHALL exist.
REQ-023 Parameter values outside the legal ranges SHALL cause an elaboration-time $fatal.
REQ-024 Behaviour SHALL be identical whether parameters are set by named override, positional override, or defparam.

Reset
REQ-025 While rstn=0 the block SHALL hold state=IDLE, pointer=0, hold counter=0, gnt=0, gnt_id=0, pulse=0 and busy=0, independent of clk.
REQ-026 Reset asserted mid-GRANT SHALL clear all outputs immediately, and SHALL NOT advance the pointer.
REQ-027 After rstn rises, the first award SHALL occur no earlier than the cycle after the first rising clk edge at which en=1 and req!=0.

Structure
REQ-028 A shared package pulse_arb_pkg SHALL hold the state enum typedef and the default constants for NUM_REQ, HOLD and GAP.
REQ-029 The combinational round-robin winner search SHALL live in one sub-module, pulse_arb_rr_pick, parameterised by NUM_REQ.

Verification
REQ-030 Defaults (NUM_REQ=4, HOLD=3, GAP=1); req=4'b0001 steady, en=1 -> gnt=0001 for 3 cycles, pulse in cycle 1 only, 1 gap cycle, then repeat; the period is 5 cycles.
REQ-031 All requesters hold req=4'b1111 -> grants follow the order 0,1,2,3,0 with gnt_id matching each grant.
REQ-032 Pointer=2 with req=4'b0011 -> requester 0 wins (wrap-around); the pointer becomes 1 afterwards.
REQ-033 req dropped and en=0 applied in the second GRANT cycle -> the grant still lasts 3 cycles, and no new grant starts while en=0.
REQ-034 rstn pulsed low in the second GRANT cycle of requester 2 -> outputs zero asynchronously; the next award with req=4'b1111 goes to requester 0.
REQ-035 Override NUM_REQ=8, HOLD=1, GAP=0 by named override, positional override and defparam in turn -> identical traces in all three, with back-to-back single-cycle grants separated by one IDLE cycle.
